// File: rtl/tx_sequence_modulator_pkg.sv
// Shared constants for the ultrasound transmit chain: carrier sine table,
// sequence-set dimensions, FSM encodings and the Kasami generator sequences.
package tx_sequence_modulator_pkg;

    localparam int SEQ_COUNT        = 16;
    localparam int SEQ_ID_W         = $clog2(SEQ_COUNT);
    localparam int KASAMI_LEN       = 255;
    localparam int KASAMI_SHORT_LEN = 15;

    localparam logic signed [15:0] SINE_AMPLITUDE = 16'sd16384;
    localparam logic signed [15:0] SINE_DIAG      = 16'sd11585;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // One carrier period in 8 samples; symmetric so negation never overflows.
    function automatic logic signed [15:0] sine_sample(input logic [2:0] k);
        logic signed [15:0] v;
        case (k)
            3'd0, 3'd4: v = 16'sd0;
            3'd1, 3'd3: v = SINE_DIAG;
            3'd2:       v = SINE_AMPLITUDE;
            3'd5, 3'd7: v = -SINE_DIAG;
            default:    v = -SINE_AMPLITUDE;
        endcase
        return v;
    endfunction

    // Maximal-length sequence from x^8 + x^4 + x^3 + x^2 + 1, seeded 1,0,0,...
    function automatic logic [KASAMI_LEN-1:0] gen_mseq();
        logic [KASAMI_LEN-1:0] s;
        s    = '0;
        s[0] = 1'b1;
        for (int n = 0; n < KASAMI_LEN - 8; n++) begin
            s[8'(n + 8)] = s[8'(n + 4)] ^ s[8'(n + 3)] ^ s[8'(n + 2)] ^ s[8'(n)];
        end
        return s;
    endfunction

    localparam logic [KASAMI_LEN-1:0] MSEQ = gen_mseq();

    // Short Kasami component: the long sequence decimated by 2^(8/2)+1 = 17.
    function automatic logic [KASAMI_SHORT_LEN-1:0] gen_short();
        logic [KASAMI_SHORT_LEN-1:0] s;
        s = '0;
        for (int j = 0; j < KASAMI_SHORT_LEN; j++) begin
            s[4'(j)] = MSEQ[8'((17 * j) % KASAMI_LEN)];
        end
        return s;
    endfunction

    localparam logic [KASAMI_SHORT_LEN-1:0] SHORT_SEQ = gen_short();

endpackage

// File: rtl/tx_sequence_modulator_rom.sv
// Spreading-sequence ROM: 16 sequences x 255 chips with a registered chip output.
// Sequence 0 is all ones (calibration tone); sequences 1..15 are the small
// Kasami set built from the long m-sequence XOR a shifted short sequence.
module tx_sequence_rom
    import tx_sequence_modulator_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SEQ_ID_W-1:0] seq_id,
    input  logic [7:0]          chip_idx,
    output logic                chip
);

    logic [3:0] short_idx;
    logic       chip_next;

    // Sequence id s selects the short-sequence shift (s-1); adding 14 is -1 mod 15.
    always_comb begin
        short_idx = 4'((9'(chip_idx) + 9'(seq_id) + 9'd14) % 9'(KASAMI_SHORT_LEN));
        if (seq_id == '0) begin
            chip_next = 1'b1;
        end else begin
            chip_next = MSEQ[chip_idx] ^ SHORT_SEQ[short_idx];
        end
    end

    // One clock of read latency, like a block ROM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chip <= 1'b0;
        end else begin
            chip <= chip_next;
        end
    end

endmodule

// File: rtl/tx_sequence_modulator.sv
// BPSK transmit modulator: spreads a sine carrier with a selected sequence and
// emits one 16-bit sample per CLK_PER_SAMPLE enabled clocks, timestamping the
// first sample. Define TX_WINDOW_EN to halve the amplitude of the first and
// last chip to limit transducer ringing; timing is identical either way.
module tx_sequence_modulator
    import tx_sequence_modulator_pkg::*;
#(
    parameter int CLK_PER_SAMPLE    = 128,
    parameter int SAMPLES_PER_CYCLE = 8,
    parameter int CYCLES_PER_CHIP   = 2,
    parameter int SEQ_LEN           = 255
) (
    input  logic                ctx_clk,
    input  logic                rtx_rst,
    input  logic                etx_en,
    input  logic [SEQ_ID_W-1:0] iseq_id,
    input  logic                itrigger_arm,
    output logic signed [15:0]  o_sample,
    output logic                o_sample_valid,
    output logic                o_busy,
    output logic                o_done,
    output logic [15:0]         o_time_arm
);

    localparam int CLK_W = (CLK_PER_SAMPLE > 1) ? $clog2(CLK_PER_SAMPLE) : 1;
    localparam int CYC_W = (CYCLES_PER_CHIP > 1) ? $clog2(CYCLES_PER_CHIP) : 1;
    localparam logic [CLK_W-1:0] CLK_LAST   = CLK_W'(CLK_PER_SAMPLE - 1);
    localparam logic [CYC_W-1:0] CYC_LAST   = CYC_W'(CYCLES_PER_CHIP - 1);
    localparam logic [2:0]       PHASE_LAST = 3'(SAMPLES_PER_CYCLE - 1);
    localparam logic [7:0]       CHIP_LAST  = 8'(SEQ_LEN - 1);

    logic [1:0]          state;
    logic [SEQ_ID_W-1:0] seq_id_q;
    logic [CLK_W-1:0]    clk_cnt;
    logic [2:0]          phase;
    logic [CYC_W-1:0]    cycle;
    logic [7:0]          chip_idx;
    logic                last_sent;
    logic [CLK_W-1:0]    ts_div;
    logic [15:0]         ts_cnt;
    logic [7:0]          rom_addr;
    logic                rom_chip;
    logic signed [15:0]  sample_next;
    logic                first_sample;

    tx_sequence_rom u_rom (
        .clk      (ctx_clk),
        .rst_n    (rtx_rst),
        .seq_id   (seq_id_q),
        .chip_idx (rom_addr),
        .chip     (rom_chip)
    );

    // LOAD points the ROM at chip 0 so it is ready for the first strobe.
    always_comb begin
        rom_addr     = (state == ST_LOAD) ? 8'd0 : chip_idx;
        first_sample = (phase == 3'd0) && (cycle == '0) && (chip_idx == 8'd0);
    end

    // BPSK: chip 1 passes the carrier, chip 0 inverts it; optional edge-chip taper.
    always_comb begin
        sample_next = rom_chip ? sine_sample(phase) : -sine_sample(phase);
`ifdef TX_WINDOW_EN
        if ((chip_idx == 8'd0) || (chip_idx == CHIP_LAST)) begin
            sample_next = sample_next >>> 1;
        end
`endif
    end

    // Free-running sample-rate timestamp shared with the receive side.
    always_ff @(posedge ctx_clk or negedge rtx_rst) begin
        if (!rtx_rst) begin
            ts_div <= '0;
            ts_cnt <= 16'd0;
        end else if (etx_en) begin
            if (ts_div == CLK_LAST) begin
                ts_div <= '0;
                ts_cnt <= ts_cnt + 16'd1;
            end else begin
                ts_div <= ts_div + 1'b1;
            end
        end
    end

    // Transmission FSM with sample pacing, chip/cycle/phase counters and outputs.
    always_ff @(posedge ctx_clk or negedge rtx_rst) begin
        if (!rtx_rst) begin
            state          <= ST_IDLE;
            seq_id_q       <= '0;
            clk_cnt        <= '0;
            phase          <= 3'd0;
            cycle          <= '0;
            chip_idx       <= 8'd0;
            last_sent      <= 1'b0;
            o_sample       <= 16'sd0;
            o_sample_valid <= 1'b0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_time_arm     <= 16'd0;
        end else begin
            o_sample_valid <= 1'b0;
            o_done         <= 1'b0;
            if (etx_en) begin
                case (state)
                    ST_IDLE: begin
                        if (itrigger_arm) begin
                            seq_id_q <= iseq_id;
                            state    <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        clk_cnt   <= '0;
                        phase     <= 3'd0;
                        cycle     <= '0;
                        chip_idx  <= 8'd0;
                        last_sent <= 1'b0;
                        o_busy    <= 1'b1;
                        state     <= ST_SEND;
                    end
                    ST_SEND: begin
                        if (last_sent) begin
                            o_done   <= 1'b1;
                            o_busy   <= 1'b0;
                            o_sample <= 16'sd0;
                            state    <= ST_DONE;
                        end else begin
                            clk_cnt <= (clk_cnt == CLK_LAST) ? '0 : clk_cnt + 1'b1;
                            if (clk_cnt == '0) begin
                                o_sample       <= sample_next;
                                o_sample_valid <= 1'b1;
                                if (first_sample) begin
                                    o_time_arm <= ts_cnt;
                                end
                                if (phase == PHASE_LAST) begin
                                    phase <= 3'd0;
                                    if (cycle == CYC_LAST) begin
                                        cycle <= '0;
                                        if (chip_idx == CHIP_LAST) begin
                                            last_sent <= 1'b1;
                                        end else begin
                                            chip_idx <= chip_idx + 8'd1;
                                        end
                                    end else begin
                                        cycle <= cycle + 1'b1;
                                    end
                                end else begin
                                    phase <= phase + 3'd1;
                                end
                            end
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tx_sequence_modulator.sv
// Self-checking bench for tx_sequence_modulator. Expected samples come from the
// Kasami construction and a real-valued sine; expected timing from counting
// enabled clocks since the trigger. A short sample interval keeps runs brief.
module tb_tx_sequence_modulator;

    localparam int CPS     = 3;
    localparam int SPC     = 8;
    localparam int CPC     = 2;
    localparam int SEQ_LEN = 255;
    localparam int TOTAL   = SEQ_LEN * CPC * SPC;

    logic               ctx_clk = 1'b0;
    logic               rtx_rst;
    logic               etx_en;
    logic [3:0]         iseq_id;
    logic               itrigger_arm;
    logic signed [15:0] o_sample;
    logic               o_sample_valid;
    logic               o_busy;
    logic               o_done;
    logic [15:0]        o_time_arm;

    int vectors     = 0;
    int miscompares = 0;
    int en_edges;
    bit kasami [16][SEQ_LEN];
    int sine_ref [SPC];
    int cap [TOTAL];

    tx_sequence_modulator #(
        .CLK_PER_SAMPLE    (CPS),
        .SAMPLES_PER_CYCLE (SPC),
        .CYCLES_PER_CHIP   (CPC),
        .SEQ_LEN           (SEQ_LEN)
    ) dut (
        .ctx_clk        (ctx_clk),
        .rtx_rst        (rtx_rst),
        .etx_en         (etx_en),
        .iseq_id        (iseq_id),
        .itrigger_arm   (itrigger_arm),
        .o_sample       (o_sample),
        .o_sample_valid (o_sample_valid),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_time_arm     (o_time_arm)
    );

    always #5 ctx_clk = ~ctx_clk;

    // Enabled clocks since reset; the timestamp is this divided by the sample interval.
    always @(posedge ctx_clk or negedge rtx_rst) begin
        if (!rtx_rst) begin
            en_edges <= 0;
        end else if (etx_en) begin
            en_edges <= en_edges + 1;
        end
    end

    task automatic check_output(input string tag, input logic signed [31:0] actual,
                                input logic signed [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Small Kasami set: m-sequence u XOR u decimated by 17, shifted by id-1.
    task automatic build_model();
        bit u [SEQ_LEN];
        for (int i = 0; i < SEQ_LEN; i++) begin
            u[i] = (i == 0);
        end
        for (int i = 8; i < SEQ_LEN; i++) begin
            u[i] = u[i-4] ^ u[i-5] ^ u[i-6] ^ u[i-8];
        end
        for (int i = 0; i < SEQ_LEN; i++) begin
            kasami[0][i] = 1'b1;
            for (int s = 1; s < 16; s++) begin
                kasami[s][i] = u[i] ^ u[(17 * ((i + s - 1) % 15)) % SEQ_LEN];
            end
        end
        for (int k = 0; k < SPC; k++) begin
            sine_ref[k] = int'(16384.0 * $sin(2.0 * 3.14159265358979 * k / 8.0));
        end
    endtask

    function automatic int exp_sample(input int sid, input int n);
        int chip_no;
        int val;
        chip_no = n / (SPC * CPC);
        val = kasami[sid][chip_no] ? sine_ref[n % SPC] : -sine_ref[n % SPC];
`ifdef TX_WINDOW_EN
        if (chip_no == 0 || chip_no == SEQ_LEN - 1) val = val >>> 1;
`endif
        return val;
    endfunction

    // One transmission: trigger, then track every clock until DONE (or abort/timeout).
    task automatic apply_stimulus(input logic [3:0] sid, input int stall_at, input bit rand_en,
                                  input bit rand_arm, input int abort_at);
        int en_cnt, strobes, cyc, budget, stall_left, prev_strobe_cyc, held;
        bit was_en, exp_v, finished, just_strobed, stall_used;
        en_cnt = 0; strobes = 0; cyc = 0; stall_left = 0; prev_strobe_cyc = 0; held = 0;
        finished = 0; just_strobed = 0; stall_used = 0;
        budget = TOTAL * CPS * 2 + 2000;
        etx_en = 1'b1; iseq_id = sid; itrigger_arm = 1'b1;
        @(posedge ctx_clk); #1;
        itrigger_arm = 1'b0;
        iseq_id = 4'($urandom);
        while (!finished && cyc < budget) begin
            itrigger_arm = 1'b0;
            if (stall_at >= 0 && just_strobed && strobes == stall_at && !stall_used) begin
                stall_left = 300;
                stall_used = 1;
            end
            if (stall_left > 0) begin
                etx_en = 1'b0;
                stall_left--;
            end else if (rand_en) begin
                etx_en = ($urandom_range(0, 7) != 0);
            end else begin
                etx_en = 1'b1;
            end
            if (just_strobed && (strobes == 100 || strobes == 2000)) begin
                itrigger_arm = 1'b1;
                iseq_id = 4'($urandom);
            end else if (rand_arm && $urandom_range(0, 63) == 0) begin
                itrigger_arm = 1'b1;
            end
            was_en = etx_en;
            @(posedge ctx_clk); #1;
            cyc++;
            just_strobed = 0;
            if (was_en) en_cnt++;
            exp_v = was_en && en_cnt >= 2 && ((en_cnt - 2) % CPS == 0) && strobes < TOTAL;
            if (was_en && en_cnt == 1) check_output("busy_rise", o_busy, 1);
            if (exp_v || o_sample_valid) check_output("valid", o_sample_valid, exp_v);
            if (exp_v) begin
                held = exp_sample(sid, strobes);
                check_output($sformatf("sample[%0d]", strobes), o_sample, held);
                if (strobes == 0) check_output("time_arm", o_time_arm, ((en_edges - 1) / CPS) % 65536);
                if (stall_used && strobes == stall_at) check_output("stall_gap", cyc - prev_strobe_cyc, CPS + 300);
                cap[strobes] = o_sample;
                prev_strobe_cyc = cyc;
                strobes++;
                just_strobed = 1;
                if (abort_at >= 0 && strobes == abort_at) begin
                    #2;
                    rtx_rst = 1'b0;
                    #1;
                    check_output("rst_sample", o_sample, 0);
                    check_output("rst_busy", o_busy, 0);
                    check_output("rst_valid", o_sample_valid, 0);
                    itrigger_arm = 1'b0;
                    etx_en = 1'b1;
                    repeat (2) @(posedge ctx_clk);
                    #2 rtx_rst = 1'b1;
                    @(posedge ctx_clk); #1;
                    check_output("rst_rel_busy", o_busy, 0);
                    check_output("rst_rel_valid", o_sample_valid, 0);
                    check_output("rst_rel_time", o_time_arm, 0);
                    return;
                end
            end else if (was_en && strobes == TOTAL) begin
                check_output("done_pulse", o_done, 1);
                check_output("done_busy", o_busy, 0);
                check_output("done_sample", o_sample, 0);
                finished = 1;
            end else if (!was_en && strobes > 0) begin
                check_output("hold", o_sample, held);
            end
        end
        if (!finished) check_output("timeout", 0, 1);
        check_output("strobe_count", strobes, TOTAL);
        itrigger_arm = 1'b0;
        etx_en = 1'b1;
        @(posedge ctx_clk); #1;
        check_output("idle_done", o_done, 0);
        check_output("idle_busy", o_busy, 0);
        @(posedge ctx_clk); #1;
        check_output("idle_valid", o_sample_valid, 0);
        check_output("idle_busy2", o_busy, 0);
    endtask

    initial begin
        int pol_id;
        build_model();
        rtx_rst = 1'b1; etx_en = 1'b0; iseq_id = 4'd0; itrigger_arm = 1'b0;
        #2 rtx_rst = 1'b0;
        repeat (3) @(posedge ctx_clk);
        #1;
        check_output("reset_sample", o_sample, 0);
        check_output("reset_valid", o_sample_valid, 0);
        check_output("reset_busy", o_busy, 0);
        check_output("reset_done", o_done, 0);
        check_output("reset_time", o_time_arm, 0);
        rtx_rst = 1'b1;
        repeat (5) @(posedge ctx_clk);
        #1;

        // Calibration tone with a 300-clock stall after strobe 10 and ignored re-triggers.
        $display("[TB] tone");
        apply_stimulus(4'd0, 10, 1'b0, 1'b0, -1);
        check_output("tone_s1", cap[0], 0);
        check_output("tone_s2", cap[1], 11585);
`ifdef TX_WINDOW_EN
        check_output("tone_s3", cap[2], 8192);
        check_output("tone_s17", cap[16], 0);
        check_output("tone_s19", cap[18], 16384);
        check_output("tone_last", cap[TOTAL-1], -5793);
`else
        check_output("tone_s3", cap[2], 16384);
        check_output("tone_s19", cap[18], 16384);
        check_output("tone_last", cap[TOTAL-1], -11585);
`endif

        // Asynchronous reset in the middle of a transmission.
        $display("[TB] reset mid-send");
        apply_stimulus(4'($urandom_range(1, 15)), -1, 1'b0, 1'b0, 50);

        // Sequence whose first chip is 0: carrier starts inverted.
        pol_id = 1;
        for (int s = 15; s >= 1; s--) begin
            if (!kasami[s][0]) pol_id = s;
        end
        $display("[TB] polarity seq %0d", pol_id);
        apply_stimulus(4'(pol_id), -1, 1'b0, 1'b0, -1);
        check_output("pol_s1", cap[0], 0);
`ifdef TX_WINDOW_EN
        check_output("pol_s2", cap[1], -5793);
        check_output("pol_s3", cap[2], -8192);
`else
        check_output("pol_s2", cap[1], -11585);
        check_output("pol_s3", cap[2], -16384);
`endif

        // Random sequence with random enable gaps and stray triggers.
        $display("[TB] random");
        apply_stimulus(4'($urandom_range(2, 15)), -1, 1'b1, 1'b1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tx_sequence_modulator.md
Name: tx_sequence_modulator

Overview:
- Transmit-side counterpart of the receive chain for the ultrasound localization system.
- On an ARM request, reads a selected 4-bit-indexed binary spreading sequence and BPSK-modulates a sine carrier with it.
- Emits 16-bit signed samples to the DAC/transducer driver at the same sample rate the receiver consumes: one sample per CLK_PER_SAMPLE clocks.
- Latches a start-of-transmission timestamp so the ARM can pair TX time with RX peak time.

Parameters:
- CLK_PER_SAMPLE, 128: clocks between sample strobes.
- SAMPLES_PER_CYCLE, 8: carrier samples per carrier period. Fixed by the sine table; only 8 is legal.
- CYCLES_PER_CHIP, 2: carrier periods per sequence chip.
- SEQ_LEN, 255: chips per sequence.

Ports:
- ctx_clk, in, 1: clock.
- rtx_rst, in, 1: asynchronous active-low reset.
- etx_en, in, 1: enable; low freezes all counters and the FSM.
- iseq_id, in, 4: sequence select, sampled with the trigger.
- itrigger_arm, in, 1: start request, level-sampled.
- o_sample, out, 16 signed: modulated sample, zero-order held between strobes.
- o_sample_valid, out, 1: one-clock strobe per new sample.
- o_busy, out, 1: transmission in progress.
- o_done, out, 1: one-clock pulse at end of transmission.
- o_time_arm, out, 16: timestamp of first sample.

Behaviour:
- Reset (rtx_rst=0, asynchronous): FSM=IDLE; all outputs and counters 0.
- Timestamp counter: 16-bit, free-running. Increments once every CLK_PER_SAMPLE enabled clocks in every state. Wraps 65535->0.
- FSM states: IDLE, LOAD, SEND, DONE.
  - IDLE: if etx_en & itrigger_arm at edge T, latch iseq_id -> LOAD. o_busy=1 from T+1.
  - LOAD (1 clk): clear chip/cycle/phase/clock counters; ROM read of chip 0 -> SEND.
  - SEND:
    - First o_sample_valid at T+2.
    - Each subsequent strobe exactly CLK_PER_SAMPLE enabled clocks after the previous one.
    - The first strobe latches the timestamp counter into o_time_arm.
    - Phase counter k runs 0..7. o_sample = chip ? SINE[k] : -SINE[k].
    - After k=7, increment the cycle counter. After CYCLES_PER_CHIP cycles, increment the chip index and prefetch the next chip.
    - After the strobe of sample SEQ_LEN*CYCLES_PER_CHIP*SAMPLES_PER_CYCLE (4080 by default) -> DONE on the next clock.
  - DONE (1 clk): o_done=1, o_busy=0, o_sample=0 -> IDLE.
- SINE table (amplitude 16384): 0, 11585, 16384, 11585, 0, -11585, -16384, -11585. Negation never overflows.
- itrigger_arm while not IDLE: ignored, no queuing. A trigger held high through DONE restarts on the next IDLE clock.
- etx_en=0: no state or counter changes, o_sample_valid=0, o_sample held. Resuming continues the remaining interval count.
- ROM read has 1-clock latency. The chip value is prefetched at least 1 clock before it is first used.
- Sequence 0 is all-ones (calibration tone). Sequences 1..15 are the Kasami set used by the receiver correlators.

Optional Feature:
- TX_WINDOW_EN defined: samples of chip 0 and chip SEQ_LEN-1 are arithmetic-shifted right by 1 (half amplitude) to limit transducer ringing.
- Undefined: all chips at full amplitude.
- Latency and strobe timing are identical in both builds.

Decomposition:
- Shared constants file uls_tx_defs.vh (package-equivalent) holds:
  - SINE table values and the amplitude constant;
  - sequence count (16) and ID width (4);
  - state encodings IDLE=0, LOAD=1, SEND=2, DONE=3.
- Sub-module tx_sequence_rom:
  - inputs: 4-bit id, 8-bit chip index;
  - output: 1-bit chip, registered;
  - holds 16 x SEQ_LEN bits.

Test Plan:
- Reset: drive rtx_rst=0 mid-SEND, between clock edges -> o_sample=0, o_busy=0, o_sample_valid=0 immediately; FSM in IDLE after release.
- Tone: iseq_id=0, trigger at T -> o_busy=1 at T+1; strobes at T+2, T+130, T+258 with 0, 11585, 16384; exactly 4080 strobes; last sample -11585; o_done one clock after the last strobe.
- Polarity: sequence with chip0=0 -> first three samples 0, -11585, -16384; o_time_arm equals the timestamp counter at T+2.
- Busy-ignore: trigger pulses at strobe 100 and strobe 2000 -> still exactly 4080 strobes, then IDLE; no second transmission.
- Stall: etx_en=0 for 300 clocks between strobes 10 and 11 -> no strobes, o_sample held; strobe-10-to-11 spacing = 428 clocks; total still 4080.
- Window: TX_WINDOW_EN defined, seq 0 -> third sample 8192, strobe 17 (chip 1) = 0, strobe 19 = 16384; undefined -> third sample 16384.
